// File: rtl/serial_byte_collector.sv
// ---------------------------------------------------------------------------
// serial_byte_collector
//
// Collects the serial_out bit stream of the upstream universal shift register
// into bytes, queues each completed byte in a small FIFO and offers the head
// byte over a valid/ready handshake.
//
// Build option:
//   SBC_HAMMING_EN  defined   -> FIFO entries are Hamming(12,8) codewords;
//                                single-bit upsets are corrected on read and
//                                flagged (rd_corrected / rd_uncorr).
//                   undefined -> FIFO entries are raw bytes; flags tied to 0.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//   MSB_FIRST  1: first received bit ends up in rd_data[7]; 0: in rd_data[0]
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   bit_en        qualifies serial_in
//   serial_in     incoming serial bit
//   flush         synchronous clear of partial byte, FIFO and overflow
//   rd_ready      consumer accepts the head byte
//   rd_valid      FIFO not empty
//   rd_data       (corrected) head byte
//   rd_corrected  head entry had a correctable error
//   rd_uncorr     head entry syndrome is 13..15
//   fifo_count    occupied entries
//   overflow      sticky: a completed byte was dropped on a full FIFO
//   bit_cnt       bits held in the partial byte
// ---------------------------------------------------------------------------
module serial_byte_collector #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_en,
    input  logic                     serial_in,
    input  logic                     flush,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_corrected,
    output logic                     rd_uncorr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [2:0]               bit_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef SBC_HAMMING_EN
    localparam int unsigned MW = 12;
`else
    localparam int unsigned MW = 8;
`endif

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("serial_byte_collector: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]    asm_reg;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [MW-1:0] mem [DEPTH];

    logic [7:0]    next_byte;
    logic          complete;
    logic          pop;
    logic          full;
    logic          accept;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] head_word;

`ifdef SBC_HAMMING_EN
    // Codeword bit i holds Hamming position i+1:
    // positions 1,2,4,8 = p1,p2,p4,p8; 3,5,6,7,9,10,11,12 = d0..d7.
    function automatic logic [11:0] ham_encode(input logic [7:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [3:0] ham_syndrome(input logic [11:0] c);
        logic [3:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8]  ^ c[10];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9]  ^ c[10];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
        s[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
        return s;
    endfunction

    function automatic logic [7:0] ham_data(input logic [11:0] c);
        return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Write side
    // -----------------------------------------------------------------------
    always_comb begin
        if (MSB_FIRST) begin
            next_byte = {asm_reg[6:0], serial_in};
        end else begin
            next_byte = {serial_in, asm_reg[7:1]};
        end
    end

    assign fifo_count = wr_ptr - rd_ptr;
    assign rd_valid   = (fifo_count != '0);
    // Occupancy never exceeds DEPTH, so the top count bit alone means full.
    assign full       = fifo_count[AW];
    assign complete   = bit_en && (bit_cnt == 3'd7);
    assign pop        = rd_valid && rd_ready;
    // A pop on the same edge frees the slot the completing byte needs.
    assign accept     = complete && (!full || pop);

`ifdef SBC_HAMMING_EN
    assign wr_word = ham_encode(next_byte);
`else
    assign wr_word = next_byte;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_reg  <= '0;
            bit_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            // Cleared so the idle head decode reads as 0x00 out of reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            asm_reg  <= '0;
            bit_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (bit_en) begin
                asm_reg <= next_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= wr_word;
                wr_ptr              <= wr_ptr + 1'b1;
            end else if (complete) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read side: combinational decode of the head entry
    // -----------------------------------------------------------------------
    assign head_word = mem[rd_ptr[AW-1:0]];

`ifdef SBC_HAMMING_EN
    logic [3:0]  syndrome;
    logic [11:0] flip_mask;

    always_comb begin
        syndrome     = ham_syndrome(head_word);
        flip_mask    = '0;
        rd_corrected = 1'b0;
        rd_uncorr    = 1'b0;
        if (syndrome >= 4'd13) begin
            rd_uncorr = 1'b1;
        end else if (syndrome != 4'd0) begin
            flip_mask    = 12'd1 << (syndrome - 4'd1);
            rd_corrected = 1'b1;
        end
        rd_data = ham_data(head_word ^ flip_mask);
    end
`else
    assign rd_data      = head_word;
    assign rd_corrected = 1'b0;
    assign rd_uncorr    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_collector.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_collector
//
// Self-checking bench for serial_byte_collector (DEPTH=4, MSB_FIRST=1).
// Directed table of bit streams, hand-written handshake/overflow/flush/reset
// sequences, Hamming correction (only when SBC_HAMMING_EN is defined) and a
// randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_serial_byte_collector;

    localparam int unsigned DEPTH     = 4;
    localparam bit          MSB_FIRST = 1'b1;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bit_en = 1'b0;
    logic          serial_in = 1'b0;
    logic          flush = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_corrected;
    logic          rd_uncorr;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [2:0]    bit_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_byte_collector #(
        .DEPTH     (DEPTH),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_en       (bit_en),
        .serial_in    (serial_in),
        .flush        (flush),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_corrected (rd_corrected),
        .rd_uncorr    (rd_uncorr),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .bit_cnt      (bit_cnt)
    );

    // stream[0] is the first bit sent
    typedef struct {
        logic [7:0] stream;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // reference model state
    logic [7:0] mq[$];
    bit         mbits[$];
    bit         movf;

`ifdef SBC_HAMMING_EN
    logic [11:0] cw_saved;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick(input logic en, input logic b, input logic rdy, input logic fl);
        bit_en    = en;
        serial_in = b;
        rd_ready  = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
        bit_en   = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(1'b1, b[i], 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},  32'(rd_valid),     0);
        check({tag, "_data"},   32'(rd_data),      0);
        check({tag, "_corr"},   32'(rd_corrected), 0);
        check({tag, "_uncorr"}, 32'(rd_uncorr),    0);
        check({tag, "_count"},  32'(fifo_count),   0);
        check({tag, "_ovf"},    32'(overflow),     0);
        check({tag, "_bitcnt"}, 32'(bit_cnt),      0);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rd_valid), 1);
        check({tag, "_data"},  32'(rd_data),  32'(exp));
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Model: one clock edge with the given inputs, from the pre-edge state.
    task automatic model_step(input bit en, input bit b, input bit rdy, input bit fl);
        int unsigned val;
        if (fl) begin
            mq.delete();
            mbits.delete();
            movf = 1'b0;
            return;
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (en) begin
            mbits.push_back(b);
            if (mbits.size() == 8) begin
                val = 0;
                for (int i = 0; i < 8; i++) begin
                    if (mbits[i]) val += MSB_FIRST ? (1 << (7 - i)) : (1 << i);
                end
                mbits.delete();
                if (mq.size() < DEPTH) mq.push_back(8'(val));
                else movf = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'b1101_1011, 8'hDB};
        vecs[1] = '{8'h01, 8'h80};
        vecs[2] = '{8'h80, 8'h01};
        vecs[3] = '{8'hF0, 8'h0F};
        vecs[4] = '{8'h12, 8'h48};
        vecs[5] = '{8'hC8, 8'h13};

        // ---------------- reset ----------------
        #12;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("rst_rel");

        // ---------------- table of streams ----------------
        foreach (vecs[v]) begin
            for (int i = 0; i < 7; i++) tick(1'b1, vecs[v].stream[i], 1'b0, 1'b0);
            check("vec_bitcnt7", 32'(bit_cnt), 7);
            check("vec_novalid", 32'(rd_valid), 0);
            tick(1'b1, vecs[v].stream[7], 1'b0, 1'b0);
            check("vec_bitcnt0", 32'(bit_cnt), 0);
            check("vec_valid",   32'(rd_valid), 1);
            check("vec_data",    32'(rd_data), 32'(vecs[v].exp_data));
            check("vec_count",   32'(fifo_count), 1);
            check("vec_corr",    32'(rd_corrected), 0);
            check("vec_uncorr",  32'(rd_uncorr), 0);
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            check("vec_popped",  32'(rd_valid), 0);
        end

        // ready with empty FIFO has no effect
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("empty_rdy_count", 32'(fifo_count), 0);
        check("empty_rdy_valid", 32'(rd_valid), 0);

        // ---------------- bit_en gap after bit 3 ----------------
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            check("gap_bitcnt", 32'(bit_cnt), 3);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_novalid", 32'(rd_valid), 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_valid", 32'(rd_valid), 1);
        check("gap_data",  32'(rd_data), 32'h DB);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // ---------------- overflow: 5 bytes into 4 entries ----------------
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        check("ovf_count", 32'(fifo_count), 4);
        check("ovf_flag",  32'(overflow), 1);
        for (int k = 1; k <= 4; k++) pop_expect("ovf_pop", 8'(k));
        check("ovf_empty",  32'(rd_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // ---------------- full FIFO, push and pop on same edge ----------------
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("fp_ovf_clr", 32'(overflow), 0);
        for (int k = 8'h11; k <= 8'h14; k++) send_byte(8'(k));
        check("fp_full", 32'(fifo_count), 4);
        for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'h55 >> i), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("fp_ovf",   32'(overflow), 0);
        check("fp_count", 32'(fifo_count), 4);
        pop_expect("fp_pop", 8'h12);
        pop_expect("fp_pop", 8'h13);
        pop_expect("fp_pop", 8'h14);
        pop_expect("fp_pop", 8'h55);
        check("fp_empty", 32'(rd_valid), 0);

        // ---------------- flush with pending state ----------------
        for (int k = 8'h21; k <= 8'h26; k++) send_byte(8'(k));
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("fl_pre_bitcnt", 32'(bit_cnt), 3);
        check("fl_pre_count",  32'(fifo_count), 2);
        check("fl_pre_ovf",    32'(overflow), 1);
        check("fl_pre_head",   32'(rd_data), 32'h23);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("fl_bitcnt", 32'(bit_cnt), 0);
        check("fl_count",  32'(fifo_count), 0);
        check("fl_valid",  32'(rd_valid), 0);
        check("fl_ovf",    32'(overflow), 0);

`ifdef SBC_HAMMING_EN
        // ---------------- single / double upset in head entry ----------------
        send_byte(8'hEF);
        check("ham_clean_data", 32'(rd_data), 32'hEF);
        check("ham_clean_corr", 32'(rd_corrected), 0);
        cw_saved = dut.mem[0];
        force dut.mem[0] = cw_saved ^ 12'h010;      // position 5 (d1)
        #1;
        check("ham_sb_data",   32'(rd_data), 32'hEF);
        check("ham_sb_corr",   32'(rd_corrected), 1);
        check("ham_sb_uncorr", 32'(rd_uncorr), 0);
        release dut.mem[0];
        force dut.mem[0] = cw_saved ^ 12'h801;      // positions 1 and 12
        #1;
        check("ham_db_uncorr", 32'(rd_uncorr), 1);
        check("ham_db_corr",   32'(rd_corrected), 0);
        check("ham_db_data",   32'(rd_data), 32'h6F);
        release dut.mem[0];
        tick(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // ---------------- randomized run vs reference model ----------------
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        mq.delete();
        mbits.delete();
        movf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit en, b, rdy, fl;
            en  = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 299) == 0);
            model_step(en, b, rdy, fl);
            tick(en, b, rdy, fl);
            check("rnd_valid",  32'(rd_valid),   (mq.size() != 0) ? 1 : 0);
            check("rnd_count",  32'(fifo_count), mq.size());
            check("rnd_bitcnt", 32'(bit_cnt),    mbits.size());
            check("rnd_ovf",    32'(overflow),   32'(movf));
            if (mq.size() != 0) check("rnd_data", 32'(rd_data), 32'(mq[0]));
        end

        // ---------------- asynchronous reset mid-byte ----------------
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("arst_pre_valid",  32'(rd_valid), 1);
        check("arst_pre_bitcnt", 32'(bit_cnt), 3);
        #2;
        rst = 1'b0;
        #1;
        check_reset("arst");
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset("arst_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
